custom_ip_seq_ctrl: RTL and testbench

//  Sequencer/arbiter in front of the custom register-mapped IP (3 x 32-bit write slots, 99-bit readback).

---
 rtl/custom_ip_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_custom_ip_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_ip_seq_ctrl.sv
// Round-robin command sequencer for the 3-slot register-mapped IP.
// Writes slots 0..2 with a per-slot ack timeout, then captures the 99-bit readback for the requester.
module custom_ip_seq_ctrl #(
    parameter int DATA_WIDTH = 96,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 16,
    parameter int READ_LAT   = 2,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [ID_W-1:0]               rsp_id_o,
    output logic [DATA_WIDTH+2:0]         rsp_data_o,
    output logic                          rsp_err_o,
    output logic [DATA_WIDTH-1:0]         reg2ip_data_o,
    output logic [2:0]                    reg2ip_en_o,
    input  logic [2:0]                    reg2ip_ack_i,
    input  logic [DATA_WIDTH+2:0]         ip2reg_data_i,
    output logic                          busy_o
);
    // state    | meaning
    // IDLE     | arbitrate, latch winning command
    // WRITE    | one-cycle enable pulse for current slot
    // WAIT_ACK | wait for IP ack, bounded by TIMEOUT
    // READ     | enables idle for READ_LAT cycles, capture readback in last
    // RESP     | hold response until accepted
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WRITE    = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_READ     = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int RD_W  = $clog2(READ_LAT + 1);

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [1:0]            slot_q, slot_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [RD_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [DATA_WIDTH+2:0] rsp_data_q, rsp_data_d;
    logic                  err_q, err_d;

    logic                  grant_vld;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       arb_cand;

    // First valid requester strictly after the last winner, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        arb_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && req_valid_i[arb_cand]) begin
                grant_vld = 1'b1;
                grant_idx = arb_cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        slot_d     = slot_q;
        timer_d    = timer_q;
        rd_cnt_d   = rd_cnt_q;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    cmd_d   = req_data_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    id_d    = grant_idx;
                    ptr_d   = grant_idx;
                    slot_d  = 2'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                timer_d = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (|reg2ip_ack_i) begin
                    if (slot_q == 2'd2) begin
                        rd_cnt_d = '0;
                        state_d  = S_READ;
                    end else begin
                        slot_d  = slot_q + 2'd1;
                        state_d = S_WRITE;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    // Timeout abandons the remaining slots.
                    err_d      = 1'b1;
                    rsp_data_d = '0;
                    state_d    = S_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_READ: begin
                if (rd_cnt_q == RD_W'(READ_LAT - 1)) begin
                    rsp_data_d = ip2reg_data_i;
                    err_d      = 1'b0;
                    state_d    = S_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q + RD_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            id_q       <= '0;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            slot_q     <= '0;
            timer_q    <= '0;
            rd_cnt_q   <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
            slot_q     <= slot_d;
            timer_q    <= timer_d;
            rd_cnt_q   <= rd_cnt_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    // Grant is combinational; masked by reset so outputs stay quiet while rst_ni is low.
    assign req_ready_o   = (rst_ni && state_q == S_IDLE && grant_vld)
                           ? (NUM_REQ'(1) << grant_idx) : '0;
    assign reg2ip_en_o   = (state_q == S_WRITE) ? (3'b001 << slot_q) : 3'b000;
    assign reg2ip_data_o = (state_q == S_WRITE || state_q == S_WAIT_ACK || state_q == S_READ)
                           ? cmd_q : '0;
    assign rsp_valid_o   = (state_q == S_RESP);
    assign rsp_id_o      = id_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_err_o     = err_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_custom_ip_seq_ctrl.sv
// Bench for custom_ip_seq_ctrl: transaction-level reference (rr queue of pending requesters,
// per-slot ack timing, expected readback) driven with directed and $urandom stimulus.
module tb_custom_ip_seq_ctrl;
    localparam int DW  = 96;
    localparam int N   = 2;
    localparam int IDW = 1;
    localparam int TO  = 16;
    localparam int RL  = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [N-1:0]      req_valid_i;
    logic [N*DW-1:0]   req_data_i;
    logic [N-1:0]      req_ready_o;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [IDW-1:0]    rsp_id_o;
    logic [DW+2:0]     rsp_data_o;
    logic              rsp_err_o;
    logic [DW-1:0]     reg2ip_data_o;
    logic [2:0]        reg2ip_en_o;
    logic [2:0]        reg2ip_ack_i;
    logic [DW+2:0]     ip2reg_data_i;
    logic              busy_o;

    custom_ip_seq_ctrl #(
        .DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT(TO), .READ_LAT(RL), .ID_W(IDW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .reg2ip_data_o(reg2ip_data_o), .reg2ip_en_o(reg2ip_en_o), .reg2ip_ack_i(reg2ip_ack_i),
        .ip2reg_data_i(ip2reg_data_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    bit            pend[N];
    logic [DW-1:0] pdata[N];
    int            ptr;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick_next();
        for (int k = 1; k <= N; k++)
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [DW-1:0] rand_cmd();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic int rand_dly();
        int p = $urandom_range(0, 7);
        if (p == 0) return TO - 1;
        if (p == 1) return TO;
        return $urandom_range(0, 3);
    endfunction

    task automatic drive_reqs();
        for (int r = 0; r < N; r++) begin
            req_valid_i[r]           = pend[r];
            req_data_i[r*DW +: DW]   = pdata[r];
        end
    endtask

    task automatic add_req(input int r, input logic [DW-1:0] d);
        if (!pend[r]) begin
            pend[r]  = 1'b1;
            pdata[r] = d;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, req_ready_o, 0);
        check_eq({tag, "_rspv"}, rsp_valid_o, 0);
        check_eq({tag, "_rspid"}, rsp_id_o, 0);
        check_eq({tag, "_rspd"}, rsp_data_o, 0);
        check_eq({tag, "_err"}, rsp_err_o, 0);
        check_eq({tag, "_en"}, reg2ip_en_o, 0);
        check_eq({tag, "_data"}, reg2ip_data_o, 0);
        check_eq({tag, "_busy"}, busy_o, 0);
    endtask

    // dN: WAIT cycle index at which the IP acks slot N (>= TO means never).
    task automatic run_txn(input int d0, input int d1, input int d2, input int hold, input bit abort);
        int            d[3];
        int            g;
        logic [DW-1:0] cmd;
        logic [DW+2:0] rd;
        logic [DW+2:0] exp_data;
        bit            exp_err;
        d[0] = d0; d[1] = d1; d[2] = d2;
        rd = '0;

        @(negedge clk_i);
        drive_reqs();
        reg2ip_ack_i = 3'b000;
        rsp_ready_i  = 1'b0;
        #1;
        g = pick_next();
        check_eq("busy_idle", busy_o, 0);
        check_eq("grant", req_ready_o, N'(1) << g);
        cmd      = pdata[g];
        ptr      = g;
        pend[g]  = 1'b0;
        pdata[g] = rand_cmd();
        exp_err  = 1'b0;

        for (int s = 0; s < 3 && !exp_err; s++) begin
            @(negedge clk_i);
            drive_reqs();
            reg2ip_ack_i = 3'($urandom_range(0, 7));
            #1;
            check_eq("en_write", reg2ip_en_o, 3'b001 << s);
            check_eq("data_write", reg2ip_data_o, cmd);
            check_eq("ready_busy", req_ready_o, 0);
            check_eq("busy_write", busy_o, 1);
            for (int j = 0; j < TO; j++) begin
                @(negedge clk_i);
                drive_reqs();
                if (abort && s == 1 && j == 1) begin
                    rst_ni       = 1'b0;
                    reg2ip_ack_i = 3'b000;
                    #1;
                    check_all_zero("rst_mid");
                    repeat (2) @(negedge clk_i);
                    rst_ni = 1'b1;
                    ptr    = N - 1;
                    return;
                end
                reg2ip_ack_i = (j == d[s]) ? 3'($urandom_range(1, 7)) : 3'b000;
                #1;
                check_eq("en_wait", reg2ip_en_o, 0);
                check_eq("data_wait", reg2ip_data_o, cmd);
                if (j == d[s]) break;
                if (j == TO - 1) exp_err = 1'b1;
            end
        end

        if (!exp_err) begin
            for (int c = 0; c < RL; c++) begin
                @(negedge clk_i);
                drive_reqs();
                reg2ip_ack_i  = 3'b000;
                rd            = {3'($urandom), $urandom, $urandom, $urandom};
                ip2reg_data_i = rd;
                #1;
                check_eq("en_read", reg2ip_en_o, 0);
                check_eq("data_read", reg2ip_data_o, cmd);
                check_eq("rspv_read", rsp_valid_o, 0);
            end
            exp_data = rd;
        end else begin
            exp_data = '0;
        end

        for (int w = 0; w <= hold; w++) begin
            @(negedge clk_i);
            drive_reqs();
            reg2ip_ack_i  = 3'b000;
            ip2reg_data_i = {3'($urandom), $urandom, $urandom, $urandom};
            rsp_ready_i   = (w == hold);
            #1;
            check_eq("rsp_valid", rsp_valid_o, 1);
            check_eq("rsp_id", rsp_id_o, g);
            check_eq("rsp_data", rsp_data_o, exp_data);
            check_eq("rsp_err", rsp_err_o, exp_err);
            check_eq("ready_resp", req_ready_o, 0);
            check_eq("en_resp", reg2ip_en_o, 0);
            check_eq("data_resp", reg2ip_data_o, 0);
        end
    endtask

    initial begin
        rst_ni        = 1'b0;
        req_valid_i   = '0;
        req_data_i    = '0;
        rsp_ready_i   = 1'b0;
        reg2ip_ack_i  = 3'b000;
        ip2reg_data_i = '0;
        for (int r = 0; r < N; r++) begin
            pend[r]  = 1'b0;
            pdata[r] = '0;
        end
        ptr = N - 1;

        repeat (2) @(negedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        add_req(0, 96'h0000000A_0000000B_0000000C);
        run_txn(0, 0, 0, 0, 1'b0);

        add_req(0, rand_cmd());
        add_req(1, rand_cmd());
        run_txn(0, 0, 0, 0, 1'b0);
        run_txn(1, 0, 2, 0, 1'b0);
        add_req(0, rand_cmd());
        add_req(1, rand_cmd());
        run_txn(0, 1, 0, 0, 1'b0);
        run_txn(TO - 1, 0, TO - 1, 0, 1'b0);

        add_req(0, rand_cmd());
        run_txn(TO, 0, 0, 0, 1'b0);

        add_req(0, rand_cmd());
        add_req(1, rand_cmd());
        run_txn(0, 0, 0, 5, 1'b0);
        run_txn(0, 3, 1, 0, 1'b0);

        add_req(1, rand_cmd());
        run_txn(0, 5, 0, 0, 1'b1);
        add_req(0, rand_cmd());
        add_req(1, rand_cmd());
        run_txn(0, 0, 0, 0, 1'b0);
        run_txn(0, 0, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < N; r++)
                if ($urandom_range(0, 1) == 1) add_req(r, rand_cmd());
            if (pick_next() < 0) add_req($urandom_range(0, N - 1), rand_cmd());
            run_txn(rand_dly(), rand_dly(), rand_dly(), $urandom_range(0, 3), 1'b0);
        end

        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        for (int r = 0; r < N; r++) pend[r] = 1'b0;
        drive_reqs();
        #1;
        check_eq("final_idle", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
